pcie_phy_fw_loader: RTL and testbench
=====================================

Name: pcie_phy_fw_loader

Overview:
Bootstrap master for the PCIe PHY firmware memories. After one start command it copies a block of words from the PHY ROM read port into the PHY SRAM, one word per cycle. It can then read back both memories and compare them. It sits beside the PHY memory top and drives the same SRAM/ROM port set the PHY uses, through an external mux that firmware controls and that is outside this block.

Parameters:
WD, 16, data width of SRAM and ROM words
PW, 15, address width of SRAM and ROM
LW, PW+1, width of length field (allows len = 2^PW)

Ports:
i_clk  in  1  single clock for the block and both memories
i_rst  in  1  synchronous active-high reset
i_start  in  1  start request, sampled only in IDLE
i_verify  in  1  sampled with i_start; 1 = run readback compare after copy
i_src_base  in  PW  first ROM address
i_dst_base  in  PW  first SRAM address
i_len  in  LW  number of words to transfer
o_busy  out  1  high from the cycle after start is accepted until the cycle before o_done
o_done  out  1  one-cycle completion pulse
o_error  out  1  verify mismatch flag, sticky until next accepted start
o_err_addr  out  PW  SRAM address of the first mismatch
o_rom_addr  out  PW  ROM address, registered
i_rom_rd_data  in  WD  ROM data, valid one cycle after address
o_sram_addr  out  PW  SRAM address, registered
o_sram_rd_en  out  1  SRAM read strobe
o_sram_wr_en  out  1  SRAM write strobe
o_sram_wr_data  out  WD  SRAM write data, registered
i_sram_rd_data  in  WD  SRAM data, valid one cycle after the rd_en cycle

Behaviour:
- Reset: state IDLE; all outputs 0; counters and captured config cleared. Reset mid-operation drops strobes on the next edge and sends no done pulse.
- States: IDLE, COPY, CDRAIN, VERIFY, VCMP, DONE.
- Cycle 0 is the cycle where i_start=1 is sampled in IDLE. At that edge the block latches src, dst, len and verify.
- i_len = 0: no memory access; o_done=1 in cycle 1; o_busy stays 0.
- i_start outside IDLE is ignored, and so is any change to the config inputs.
- COPY, cycles 1..len:
  - o_rom_addr = src+k in cycle k+1.
  - Registered write pipeline: in cycle k+3, o_sram_wr_en=1, o_sram_addr=dst+k, o_sram_wr_data = ROM word for src+k.
  - Last write is in cycle len+2 (CDRAIN covers the one-cycle tail).
  - Sustained throughput: 1 word/cycle.
- Without verify: o_done pulses in cycle len+3.
- VERIFY:
  - Read issue: cycles len+3..2len+2. Read k is in cycle len+3+k: o_sram_rd_en=1, o_sram_addr=dst+k, o_rom_addr=src+k.
  - Compare: i_sram_rd_data vs i_rom_rd_data in the following cycle.
  - No mismatch: o_done pulses in cycle 2len+4.
- Mismatch at compare cycle c:
  - o_error=1 and o_err_addr=dst+k are registered, visible from c+1.
  - Reads stop from c+1; any read issued in c is discarded.
  - o_done pulses in c+1. Only the first mismatch is captured.
- o_sram_rd_en and o_sram_wr_en are never high in the same cycle.
- Strobes are 0 whenever o_busy=0.
- Addresses are computed modulo 2^PW, so wrap-around past the top address is legal and silent.
- Internal counter is LW bits wide; len = 2^PW must work.
- DONE lasts one cycle and returns to IDLE. A start in the DONE cycle is ignored; the earliest new start is sampled in the cycle after o_done.
- o_busy=1 exactly in cycles 1 .. done-1.

Test Plan:
- len=4, src=0x0100, dst=0x0020, verify=0, ROM[0x100..0x103]=A1,B2,C3,D4 -> wr_en in cycles 3..6 at 0x20..0x23 with A1..D4; o_done in cycle 7; o_error=0.
- Same transfer with verify=1 and ideal memories -> rd_en in cycles 7..10, no write overlap, o_done in cycle 12, o_error=0.
- verify=1, bench corrupts SRAM word 0x0022 after copy -> o_error=1, o_err_addr=0x0022, no rd_en after cycle 10, o_done in cycle 11.
- dst=0x7FFE, len=4 -> write addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001; no error.
- i_start pulsed during COPY with different config, and i_rst asserted at cycle 4 of a len=8 copy -> second start ignored; after reset all outputs are 0, no o_done, and a fresh start behaves as in scenario 1.
- len=0 -> o_done in cycle 1, o_busy never high, no strobes; len=0x8000 -> last write in cycle 0x8002, o_done in cycle 0x8003.

Source files
------------

// File: rtl/pcie_phy_fw_loader.sv
// Bootstrap master for the PCIe PHY firmware memories: streams a block of ROM words
// into SRAM at one word per cycle, then optionally reads both back and compares them.
module pcie_phy_fw_loader #(
    parameter int WD = 16,
    parameter int PW = 15,
    parameter int LW = PW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_verify,
    input  logic [PW-1:0] i_src_base,
    input  logic [PW-1:0] i_dst_base,
    input  logic [LW-1:0] i_len,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_error,
    output logic [PW-1:0] o_err_addr,
    output logic [PW-1:0] o_rom_addr,
    input  logic [WD-1:0] i_rom_rd_data,
    output logic [PW-1:0] o_sram_addr,
    output logic          o_sram_rd_en,
    output logic          o_sram_wr_en,
    output logic [WD-1:0] o_sram_wr_data,
    input  logic [WD-1:0] i_sram_rd_data
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COPY   = 3'd1,
        ST_CDRAIN = 3'd2,
        ST_VERIFY = 3'd3,
        ST_VCMP   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t        state_r;
    logic [PW-1:0] src_r;
    logic [PW-1:0] dst_r;
    logic [LW-1:0] len_r;
    logic [LW-1:0] iss_r;
    logic [LW-1:0] idx_r;
    logic          verify_r;
    logic          rv_r;
    logic          cmp_v_r;
    logic          mismatch_s;

    // Addresses wrap silently at the top of the PW-bit space.
    function automatic logic [PW-1:0] addr_at(input logic [PW-1:0] base, input logic [LW-1:0] idx);
        return PW'(LW'(base) + idx);
    endfunction

    assign mismatch_s = cmp_v_r && (i_sram_rd_data != i_rom_rd_data);

    // Sequencer: issues ROM reads, registers SRAM writes, runs the readback compare.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r        <= ST_IDLE;
            src_r          <= '0;
            dst_r          <= '0;
            len_r          <= '0;
            iss_r          <= '0;
            idx_r          <= '0;
            verify_r       <= 1'b0;
            rv_r           <= 1'b0;
            cmp_v_r        <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
            o_err_addr     <= '0;
            o_rom_addr     <= '0;
            o_sram_addr    <= '0;
            o_sram_rd_en   <= 1'b0;
            o_sram_wr_en   <= 1'b0;
            o_sram_wr_data <= '0;
        end else begin
            o_done       <= 1'b0;
            o_sram_rd_en <= 1'b0;
            o_sram_wr_en <= 1'b0;
            rv_r         <= 1'b0;
            // SRAM read data is valid the cycle after the strobe.
            cmp_v_r      <= o_sram_rd_en;
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        src_r      <= i_src_base;
                        dst_r      <= i_dst_base;
                        len_r      <= i_len;
                        verify_r   <= i_verify;
                        idx_r      <= '0;
                        o_error    <= 1'b0;
                        o_err_addr <= '0;
                        if (i_len == '0) begin
                            iss_r   <= '0;
                            o_done  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            iss_r      <= LW'(1);
                            o_rom_addr <= i_src_base;
                            o_busy     <= 1'b1;
                            state_r    <= ST_COPY;
                        end
                    end
                end
                ST_COPY: begin
                    rv_r <= 1'b1;
                    if (rv_r) begin
                        o_sram_wr_en   <= 1'b1;
                        o_sram_addr    <= addr_at(dst_r, idx_r);
                        o_sram_wr_data <= i_rom_rd_data;
                        idx_r          <= idx_r + LW'(1);
                    end
                    if (iss_r != len_r) begin
                        o_rom_addr <= addr_at(src_r, iss_r);
                        iss_r      <= iss_r + LW'(1);
                    end else begin
                        state_r <= ST_CDRAIN;
                    end
                end
                ST_CDRAIN: begin
                    if (rv_r) begin
                        o_sram_wr_en   <= 1'b1;
                        o_sram_addr    <= addr_at(dst_r, idx_r);
                        o_sram_wr_data <= i_rom_rd_data;
                        idx_r          <= idx_r + LW'(1);
                    end else begin
                        idx_r <= '0;
                        if (verify_r) begin
                            o_sram_rd_en <= 1'b1;
                            o_sram_addr  <= dst_r;
                            o_rom_addr   <= src_r;
                            iss_r        <= LW'(1);
                            state_r      <= ST_VERIFY;
                        end else begin
                            o_done  <= 1'b1;
                            o_busy  <= 1'b0;
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (mismatch_s) begin
                        o_error    <= 1'b1;
                        o_err_addr <= addr_at(dst_r, idx_r);
                        o_done     <= 1'b1;
                        o_busy     <= 1'b0;
                        state_r    <= ST_DONE;
                    end else begin
                        if (cmp_v_r) begin
                            idx_r <= idx_r + LW'(1);
                        end
                        if (iss_r != len_r) begin
                            o_sram_rd_en <= 1'b1;
                            o_sram_addr  <= addr_at(dst_r, iss_r);
                            o_rom_addr   <= addr_at(src_r, iss_r);
                            iss_r        <= iss_r + LW'(1);
                        end else begin
                            state_r <= ST_VCMP;
                        end
                    end
                end
                ST_VCMP: begin
                    if (mismatch_s) begin
                        o_error    <= 1'b1;
                        o_err_addr <= addr_at(dst_r, idx_r);
                    end
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pcie_phy_fw_loader.sv
// Bench for pcie_phy_fw_loader: ROM/SRAM models, directed vector table, reset/ignore
// sequence and randomized transfers checked against a cycle-level reference model.
module tb_pcie_phy_fw_loader;
    localparam int WD    = 16;
    localparam int PW    = 15;
    localparam int LW    = 16;
    localparam int DEPTH = 1 << PW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          verify;
    logic [PW-1:0] src_base;
    logic [PW-1:0] dst_base;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          error;
    logic [PW-1:0] err_addr;
    logic [PW-1:0] rom_addr;
    logic [WD-1:0] rom_rd_data;
    logic [PW-1:0] sram_addr;
    logic          sram_rd_en;
    logic          sram_wr_en;
    logic [WD-1:0] sram_wr_data;
    logic [WD-1:0] sram_rd_data;

    logic [WD-1:0] rom  [0:DEPTH-1];
    logic [WD-1:0] sram [0:DEPTH-1];
    logic          corrupt_en;
    logic [PW-1:0] corrupt_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pcie_phy_fw_loader #(.WD(WD), .PW(PW), .LW(LW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_verify      (verify),
        .i_src_base    (src_base),
        .i_dst_base    (dst_base),
        .i_len         (len),
        .o_busy        (busy),
        .o_done        (done),
        .o_error       (error),
        .o_err_addr    (err_addr),
        .o_rom_addr    (rom_addr),
        .i_rom_rd_data (rom_rd_data),
        .o_sram_addr   (sram_addr),
        .o_sram_rd_en  (sram_rd_en),
        .o_sram_wr_en  (sram_wr_en),
        .o_sram_wr_data(sram_wr_data),
        .i_sram_rd_data(sram_rd_data)
    );

    // Memory models with one-cycle read latency; corrupt_en flips one stored word.
    always @(posedge clk) begin
        rom_rd_data <= rom[rom_addr];
        if (sram_rd_en) sram_rd_data <= sram[sram_addr];
        if (sram_wr_en) sram[sram_addr] <= (corrupt_en && sram_addr == corrupt_addr) ? ~sram_wr_data : sram_wr_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: done cycle from the transfer rules (cycle 0 = start sampled).
    function automatic int model_done(input int n, input bit v, input int mis_k);
        if (n == 0) return 1;
        if (!v) return n + 3;
        if (mis_k >= 0) return n + 5 + mis_k;
        return 2 * n + 4;
    endfunction

    task automatic run_op(input string tag, input logic [PW-1:0] s, input logic [PW-1:0] d, input int n,
                          input bit v, input bit cor, input int cor_k,
                          output int done_cyc, output logic err_o, output logic [PW-1:0] ea_o);
        int mis_k, exp_done, exp_nrd, nwr, nrd, viol, limit;
        mis_k    = (v && cor && n != 0) ? cor_k : -1;
        exp_done = model_done(n, v, mis_k);
        if (!v || n == 0) exp_nrd = 0;
        else if (mis_k >= 0) exp_nrd = (mis_k + 2 < n) ? mis_k + 2 : n;
        else exp_nrd = n;
        corrupt_en   = cor;
        corrupt_addr = PW'(d + cor_k);
        @(negedge clk);
        src_base = s; dst_base = d; len = LW'(n); verify = v; start = 1'b1;
        done_cyc = -1; nwr = 0; nrd = 0; viol = 0; limit = exp_done + 3;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done && done_cyc < 0) done_cyc = c;
            else if (done) viol++;
            if (busy !== (c < exp_done)) viol++;
            if ((sram_wr_en || sram_rd_en) && !busy) viol++;
            if (sram_wr_en && sram_rd_en) viol++;
            if (c <= n && rom_addr !== PW'(s + c - 1)) viol++;
            if (sram_wr_en) begin
                if (c != nwr + 3 || sram_addr !== PW'(d + nwr) || sram_wr_data !== rom[PW'(s + nwr)]) viol++;
                nwr++;
            end
            if (sram_rd_en) begin
                if (c != n + 3 + nrd || sram_addr !== PW'(d + nrd) || rom_addr !== PW'(s + nrd)) viol++;
                nrd++;
            end
        end
        err_o = error;
        ea_o  = err_addr;
        corrupt_en = 1'b0;
        check({tag, "_writes"}, 64'(nwr), 64'(n));
        check({tag, "_reads"}, 64'(nrd), 64'(exp_nrd));
        check({tag, "_protocol"}, 64'(viol), 64'd0);
    endtask

    typedef struct {
        logic [PW-1:0] src;
        logic [PW-1:0] dst;
        int            len;
        bit            vfy;
        bit            cor;
        int            cor_k;
        int            exp_done;
        bit            exp_err;
        logic [PW-1:0] exp_ea;
    } vec_t;

    initial begin
        vec_t          vecs [7];
        int            dc, viol, n, k;
        logic          eo;
        logic [PW-1:0] ea, s, d;
        bit            v, cor;

        vecs[0] = '{15'h0100, 15'h0020, 4,       1'b0, 1'b0, 0, 7,       1'b0, 15'h0000};
        vecs[1] = '{15'h0100, 15'h0020, 4,       1'b1, 1'b0, 0, 12,      1'b0, 15'h0000};
        vecs[2] = '{15'h0100, 15'h0020, 4,       1'b1, 1'b1, 2, 11,      1'b1, 15'h0022};
        vecs[3] = '{15'h0100, 15'h7FFE, 4,       1'b1, 1'b0, 0, 12,      1'b0, 15'h0000};
        vecs[4] = '{15'h0100, 15'h0020, 0,       1'b1, 1'b0, 0, 1,       1'b0, 15'h0000};
        vecs[5] = '{15'h0000, 15'h0000, 32'h8000, 1'b0, 1'b0, 0, 32'h8003, 1'b0, 15'h0000};
        vecs[6] = '{15'h7FFF, 15'h7FFF, 1,       1'b1, 1'b1, 0, 6,       1'b1, 15'h7FFF};

        for (int i = 0; i < DEPTH; i++) rom[i] = WD'($urandom);
        rom[15'h0100] = 16'h00A1; rom[15'h0101] = 16'h00B2;
        rom[15'h0102] = 16'h00C3; rom[15'h0103] = 16'h00D4;
        corrupt_en = 1'b0; corrupt_addr = '0;
        rst = 1'b1; start = 1'b0; verify = 1'b0; src_base = '0; dst_base = '0; len = '0;
        repeat (3) @(negedge clk);
        check("reset_ctl", 64'({busy, done, error, sram_rd_en, sram_wr_en}), 64'd0);
        check("reset_addr", 64'({err_addr, rom_addr, sram_addr}), 64'd0);
        check("reset_wdata", 64'(sram_wr_data), 64'd0);
        rst = 1'b0;

        // Start during COPY is ignored; reset in cycle 4 kills the transfer silently.
        @(negedge clk);
        src_base = 15'h0300; dst_base = 15'h0040; len = 16'd8; verify = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        src_base = 15'h0500; dst_base = 15'h0010; len = 16'd2; verify = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_rom_addr_c3", 64'(rom_addr), 64'h0302);
        check("ign_wr_c3", 64'({sram_wr_en, sram_addr}), 64'({1'b1, 15'h0040}));
        @(negedge clk);
        check("ign_wr_c4", 64'({sram_wr_en, sram_addr, rom_addr}), 64'({1'b1, 15'h0041, 15'h0303}));
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ctl", 64'({busy, done, error, sram_rd_en, sram_wr_en}), 64'd0);
        check("midrst_addr", 64'({err_addr, rom_addr, sram_addr}), 64'd0);
        rst = 1'b0;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy || sram_rd_en || sram_wr_en) viol++;
        end
        check("midrst_quiet", 64'(viol), 64'd0);

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].vfy,
                   vecs[i].cor, vecs[i].cor_k, dc, eo, ea);
            check($sformatf("vec%0d_done", i), 64'(dc), 64'(vecs[i].exp_done));
            check($sformatf("vec%0d_error", i), 64'(eo), 64'(vecs[i].exp_err));
            if (vecs[i].exp_err) check($sformatf("vec%0d_err_addr", i), 64'(ea), 64'(vecs[i].exp_ea));
        end

        for (int t = 0; t < 12; t++) begin
            s   = PW'($urandom);
            d   = PW'($urandom);
            n   = int'($urandom_range(1, 40));
            v   = 1'($urandom_range(0, 1));
            cor = v && ($urandom_range(0, 1) == 1);
            k   = int'($urandom_range(0, n - 1));
            run_op($sformatf("rnd%0d", t), s, d, n, v, cor, k, dc, eo, ea);
            check($sformatf("rnd%0d_done", t), 64'(dc), 64'(model_done(n, v, cor ? k : -1)));
            check($sformatf("rnd%0d_error", t), 64'(eo), 64'(cor));
            if (cor) check($sformatf("rnd%0d_err_addr", t), 64'(ea), 64'(PW'(d + k)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
